// File: rtl/syscall_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : syscall_unit                                                |
// | Description: Services writeback-stage syscall requests. Handles          |
// |              print_int (decimal formatting), print_char, exit and,       |
// |              when SYSCALL_PRINT_STRING_EN is defined, print_string.      |
// |              Bytes leave on a valid/ready port; completion is a one-     |
// |              cycle sys_ack pulse.                                        |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module syscall_unit #(
  parameter int ACK_HOLD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sys_valid,
  input  logic [31:0] sys_v0,
  input  logic [31:0] sys_a0,
  output logic        sys_ack,
  output logic        sys_busy,
  output logic        chr_valid,
  output logic [7:0]  chr_data,
  input  logic        chr_ready,
  output logic        halted,
  output logic        bad_code
`ifdef SYSCALL_PRINT_STRING_EN
  ,
  output logic [31:0] str_addr,
  output logic        str_rd,
  input  logic [7:0]  str_data
`endif
);

  localparam logic [31:0] c_CODE_PRINT_INT  = 32'd1;
  localparam logic [31:0] c_CODE_PRINT_CHAR = 32'd11;
  localparam logic [31:0] c_CODE_EXIT       = 32'd10;
`ifdef SYSCALL_PRINT_STRING_EN
  localparam logic [31:0] c_CODE_PRINT_STR  = 32'd4;
`endif

  // print_char loads its byte straight from IDLE into EMIT so that the
  // character is presented in the first cycle after acceptance.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INT_SIGN = 4'd1,
    S_INT_DIG  = 4'd2,
    S_EMIT     = 4'd3,
    S_ACK      = 4'd4,
    S_HALT     = 4'd5,
    S_STR_REQ  = 4'd6,
    S_STR_WAIT = 4'd7
  } stateT;

  stateT       r_state, w_stateNext;
  stateT       r_ret, w_retNext;
  logic [31:0] r_a0, w_a0Next;
  logic [31:0] r_rem, w_remNext;
  logic [3:0]  r_powIdx, w_powIdxNext;
  logic [3:0]  r_digit, w_digitNext;
  logic        r_started, w_startedNext;
  logic        r_chrValid, w_chrValidNext;
  logic [7:0]  r_chrData, w_chrDataNext;
  logic        r_halted, w_haltedNext;
  logic        r_badCode, w_badCodeNext;
  logic [31:0] r_holdCnt, w_holdCntNext;
  logic [31:0] w_power;
  logic [7:0]  w_digitChar;
`ifdef SYSCALL_PRINT_STRING_EN
  logic [31:0] r_ptr, w_ptrNext;
`endif

  function automatic logic [31:0] powerOf10(input logic [3:0] idx);
    case (idx)
      4'd0:    powerOf10 = 32'd1;
      4'd1:    powerOf10 = 32'd10;
      4'd2:    powerOf10 = 32'd100;
      4'd3:    powerOf10 = 32'd1000;
      4'd4:    powerOf10 = 32'd10000;
      4'd5:    powerOf10 = 32'd100000;
      4'd6:    powerOf10 = 32'd1000000;
      4'd7:    powerOf10 = 32'd10000000;
      4'd8:    powerOf10 = 32'd100000000;
      4'd9:    powerOf10 = 32'd1000000000;
      default: powerOf10 = 32'd1;
    endcase
  endfunction

  // State and datapath registers; reset clears everything including halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ret      <= S_IDLE;
      r_a0       <= 32'd0;
      r_rem      <= 32'd0;
      r_powIdx   <= 4'd0;
      r_digit    <= 4'd0;
      r_started  <= 1'b0;
      r_chrValid <= 1'b0;
      r_chrData  <= 8'd0;
      r_halted   <= 1'b0;
      r_badCode  <= 1'b0;
      r_holdCnt  <= 32'd0;
`ifdef SYSCALL_PRINT_STRING_EN
      r_ptr      <= 32'd0;
`endif
    end else begin
      r_state    <= w_stateNext;
      r_ret      <= w_retNext;
      r_a0       <= w_a0Next;
      r_rem      <= w_remNext;
      r_powIdx   <= w_powIdxNext;
      r_digit    <= w_digitNext;
      r_started  <= w_startedNext;
      r_chrValid <= w_chrValidNext;
      r_chrData  <= w_chrDataNext;
      r_halted   <= w_haltedNext;
      r_badCode  <= w_badCodeNext;
      r_holdCnt  <= w_holdCntNext;
`ifdef SYSCALL_PRINT_STRING_EN
      r_ptr      <= w_ptrNext;
`endif
    end
  end

  // Next-state logic: decode, digit extraction, byte hand-off and ack timing.
  always_comb begin
    w_stateNext    = r_state;
    w_retNext      = r_ret;
    w_a0Next       = r_a0;
    w_remNext      = r_rem;
    w_powIdxNext   = r_powIdx;
    w_digitNext    = r_digit;
    w_startedNext  = r_started;
    w_chrValidNext = r_chrValid;
    w_chrDataNext  = r_chrData;
    w_haltedNext   = r_halted;
    w_badCodeNext  = 1'b0;
    w_holdCntNext  = r_holdCnt;
    sys_ack        = 1'b0;
    w_power        = powerOf10(r_powIdx);
    w_digitChar    = 8'h30 + {4'd0, r_digit};
`ifdef SYSCALL_PRINT_STRING_EN
    w_ptrNext      = r_ptr;
    str_rd         = 1'b0;
    str_addr       = 32'd0;
`endif
    case (r_state)
      S_IDLE: begin
        if (sys_valid) begin
          w_a0Next = sys_a0;
          if (sys_v0 == c_CODE_PRINT_INT) begin
            w_stateNext = S_INT_SIGN;
          end else if (sys_v0 == c_CODE_PRINT_CHAR) begin
            w_chrValidNext = 1'b1;
            w_chrDataNext  = sys_a0[7:0];
            w_retNext      = S_ACK;
            w_stateNext    = S_EMIT;
          end else if (sys_v0 == c_CODE_EXIT) begin
            w_haltedNext = 1'b1;
            w_stateNext  = S_ACK;
`ifdef SYSCALL_PRINT_STRING_EN
          end else if (sys_v0 == c_CODE_PRINT_STR) begin
            w_ptrNext   = sys_a0;
            w_stateNext = S_STR_REQ;
`endif
          end else begin
            w_badCodeNext = 1'b1;
            w_stateNext   = S_ACK;
          end
        end
      end
      S_INT_SIGN: begin
        // Two's-complement negate; 0x80000000 maps onto itself as unsigned.
        w_remNext     = r_a0[31] ? (~r_a0 + 32'd1) : r_a0;
        w_powIdxNext  = 4'd9;
        w_digitNext   = 4'd0;
        w_startedNext = 1'b0;
        if (r_a0[31]) begin
          w_chrValidNext = 1'b1;
          w_chrDataNext  = 8'h2D;
          w_retNext      = S_INT_DIG;
          w_stateNext    = S_EMIT;
        end else begin
          w_stateNext = S_INT_DIG;
        end
      end
      S_INT_DIG: begin
        if (r_rem >= w_power) begin
          w_remNext   = r_rem - w_power;
          w_digitNext = r_digit + 4'd1;
        end else begin
          w_digitNext  = 4'd0;
          w_powIdxNext = r_powIdx - 4'd1;
          // Leading zeros are suppressed, but the units digit always prints.
          if ((r_digit != 4'd0) || r_started || (r_powIdx == 4'd0)) begin
            w_startedNext  = 1'b1;
            w_chrValidNext = 1'b1;
            w_chrDataNext  = w_digitChar;
            w_retNext      = (r_powIdx == 4'd0) ? S_ACK : S_INT_DIG;
            w_stateNext    = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (chr_ready) begin
          w_chrValidNext = 1'b0;
          w_stateNext    = r_ret;
        end
      end
      S_ACK: begin
        if (r_holdCnt == 32'(ACK_HOLD)) begin
          sys_ack       = 1'b1;
          w_holdCntNext = 32'd0;
          w_stateNext   = r_halted ? S_HALT : S_IDLE;
        end else begin
          w_holdCntNext = r_holdCnt + 32'd1;
        end
      end
      S_HALT: begin
        w_stateNext = S_HALT;
      end
`ifdef SYSCALL_PRINT_STRING_EN
      S_STR_REQ: begin
        str_rd      = 1'b1;
        str_addr    = r_ptr;
        w_stateNext = S_STR_WAIT;
      end
      S_STR_WAIT: begin
        if (str_data == 8'd0) begin
          w_stateNext = S_ACK;
        end else begin
          w_chrValidNext = 1'b1;
          w_chrDataNext  = str_data;
          w_ptrNext      = r_ptr + 32'd1;
          w_retNext      = S_STR_REQ;
          w_stateNext    = S_EMIT;
        end
      end
`endif
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign sys_busy  = (r_state != S_IDLE);
  assign chr_valid = r_chrValid;
  assign chr_data  = r_chrData;
  assign halted    = r_halted;
  assign bad_code  = r_badCode;

endmodule
`default_nettype wire

// File: tb/tb_syscall_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_syscall_unit                                             |
// | Description: Directed self-checking bench for syscall_unit.              |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sys_valid;
  logic [31:0] sys_v0;
  logic [31:0] sys_a0;
  logic        sys_ack;
  logic        sys_busy;
  logic        chr_valid;
  logic [7:0]  chr_data;
  logic        chr_ready;
  logic        halted;
  logic        bad_code;
`ifdef SYSCALL_PRINT_STRING_EN
  logic [31:0] str_addr;
  logic        str_rd;
  logic [7:0]  str_data;
  logic [7:0]  strMem [0:511];
  logic [31:0] rdAddrs[$];
`endif

  syscall_unit #(.ACK_HOLD(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .sys_valid (sys_valid),
    .sys_v0    (sys_v0),
    .sys_a0    (sys_a0),
    .sys_ack   (sys_ack),
    .sys_busy  (sys_busy),
    .chr_valid (chr_valid),
    .chr_data  (chr_data),
    .chr_ready (chr_ready),
    .halted    (halted),
    .bad_code  (bad_code)
`ifdef SYSCALL_PRINT_STRING_EN
    ,
    .str_addr  (str_addr),
    .str_rd    (str_rd),
    .str_data  (str_data)
`endif
  );

  always #5 clk = ~clk;

  int         vecCount = 0;
  int         errCount = 0;
  logic [7:0] gotBytes[$];
  int         ackCnt = 0;
  int         badCnt = 0;
  int         byteBase, ackBase, badBase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Sink monitor: records accepted bytes, ack and bad_code pulses mid-cycle.
  always @(negedge clk) begin
    if (chr_valid && chr_ready) gotBytes.push_back(chr_data);
    if (sys_ack) ackCnt++;
    if (bad_code) badCnt++;
`ifdef SYSCALL_PRINT_STRING_EN
    if (str_rd) begin
      rdAddrs.push_back(str_addr);
      str_data = strMem[str_addr[8:0]];
    end
`endif
  end

  task automatic markBases();
    byteBase = gotBytes.size();
    ackBase  = ackCnt;
    badBase  = badCnt;
  endtask

  task automatic startReq(input logic [31:0] v0, input logic [31:0] a0);
    @(posedge clk); #1;
    sys_v0    = v0;
    sys_a0    = a0;
    sys_valid = 1'b1;
  endtask

  task automatic waitAck(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (sys_ack) seen = 1'b1;
    end
    sys_valid = 1'b0;
    chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic doReq(input string tag, input logic [31:0] v0, input logic [31:0] a0);
    markBases();
    startReq(v0, a0);
    waitAck(tag, 200);
  endtask

  task automatic checkBytes(input string tag, input string exp);
    int n;
    logic [7:0] got;
    n = gotBytes.size() - byteBase;
    chk({tag, "_len"}, 32'(n), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      got = (i < n) ? gotBytes[byteBase + i] : 8'hFF;
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
    end
  endtask

  task automatic checkCounts(input string tag, input int acks, input int bads);
    chk({tag, "_acks"}, 32'(ackCnt - ackBase), 32'(acks));
    chk({tag, "_bad"}, 32'(badCnt - badBase), 32'(bads));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SYSCALL_PRINT_STRING_EN
    for (int i = 0; i < 512; i++) strMem[i] = 8'h00;
    strMem[9'h100] = 8'h48;
    strMem[9'h101] = 8'h69;
    strMem[9'h102] = 8'h00;
    str_data = 8'h00;
`endif
    rst = 1'b1; sys_valid = 1'b0; sys_v0 = 32'd0; sys_a0 = 32'd0; chr_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", {31'd0, sys_busy}, 32'd0);
    chk("rst_chr_valid", {31'd0, chr_valid}, 32'd0);
    chk("rst_chr_data", {24'd0, chr_data}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_ack", {31'd0, sys_ack}, 32'd0);
    chk("rst_bad", {31'd0, bad_code}, 32'd0);
    rst = 1'b0;

    // print_char cycle timing with ready high
    markBases();
    startReq(32'd11, 32'h41);
    @(posedge clk);
    @(negedge clk);
    chk("pc_c1_valid", {31'd0, chr_valid}, 32'd1);
    chk("pc_c1_data", {24'd0, chr_data}, 32'h41);
    chk("pc_c1_busy", {31'd0, sys_busy}, 32'd1);
    chk("pc_c1_ack", {31'd0, sys_ack}, 32'd0);
    @(negedge clk);
    chk("pc_c2_ack", {31'd0, sys_ack}, 32'd1);
    chk("pc_c2_valid", {31'd0, chr_valid}, 32'd0);
    sys_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkBytes("pc", "A");
    checkCounts("pc", 1, 0);

    doReq("int0", 32'd1, 32'd0);
    checkBytes("int0", "0");
    checkCounts("int0", 1, 0);

    doReq("intm1", 32'd1, 32'hFFFF_FFFF);
    checkBytes("intm1", "-1");

    doReq("intmin", 32'd1, 32'h8000_0000);
    checkBytes("intmin", "-2147483648");

    doReq("int1e9", 32'd1, 32'd1000000000);
    checkBytes("int1e9", "1000000000");

    // back-pressure: byte must stay put while ready is low
    chr_ready = 1'b0;
    markBases();
    startReq(32'd11, 32'h41);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k), {31'd0, chr_valid}, 32'd1);
      chk($sformatf("bp_data%0d", k), {24'd0, chr_data}, 32'h41);
    end
    @(posedge clk); #1;
    chr_ready = 1'b1;
    waitAck("bp", 50);
    checkBytes("bp", "A");
    checkCounts("bp", 1, 0);

    doReq("bad99", 32'd99, 32'd0);
    checkBytes("bad99", "");
    checkCounts("bad99", 1, 1);

`ifdef SYSCALL_PRINT_STRING_EN
    rdAddrs.delete();
    doReq("str", 32'd4, 32'h100);
    checkBytes("str", "Hi");
    checkCounts("str", 1, 0);
    chk("str_nreads", 32'(rdAddrs.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("str_addr%0d", i), (i < rdAddrs.size()) ? rdAddrs[i] : 32'hFFFF_FFFF,
          32'h100 + 32'(i));
`else
    doReq("code4", 32'd4, 32'h100);
    checkBytes("code4", "");
    checkCounts("code4", 1, 1);
`endif

    // async reset in the middle of print_int, then a clean re-run
    markBases();
    startReq(32'd1, 32'd12345);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    sys_valid = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, chr_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, sys_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    doReq("int12345", 32'd1, 32'd12345);
    checkBytes("int12345", "12345");
    checkCounts("int12345", 1, 0);

    // exit: halted and ack one cycle after accept
    markBases();
    startReq(32'd10, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("exit_halted", {31'd0, halted}, 32'd1);
    chk("exit_ack", {31'd0, sys_ack}, 32'd1);
    sys_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkCounts("exit", 1, 0);

    // requests after exit are ignored
    markBases();
    startReq(32'd11, 32'h42);
    repeat (20) @(negedge clk);
    checkBytes("halt", "");
    checkCounts("halt", 0, 0);
    chk("halt_busy", {31'd0, sys_busy}, 32'd1);
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    #2;
    sys_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    chk("halt_rst_busy", {31'd0, sys_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    doReq("after_halt", 32'd11, 32'h5A);
    checkBytes("after_halt", "Z");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
`default_nettype wire
